// File: rtl/i2s_sample_transmitter.sv
// i2s_sample_transmitter: serialises a mono 24-bit sample into an I2S stream, sending the same word in the left and right slots.
// Latency: a sample accepted before frame boundary N has its MSB on sdata one bclk falling edge after boundary N.
// Backpressure: sample_ready is low while the one-entry holding register is full, and it clears at each frame boundary.
// Ports: clk/reset (sync, active-high); sample_in/sample_valid/sample_ready input handshake;
//        mute (sampled at frame boundaries); bclk/lrclk/sdata I2S outputs; frame_start/underrun status pulses.
module i2s_sample_transmitter #(
  parameter int BCLK_DIV      = 8,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        mute,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam int          DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [23:0] MIDSCALE = OFFSET_BINARY ? 24'h800000 : 24'h000000;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic               bclk_q, lrclk_q, sdata_q, sdata_d;
  logic               frame_start_q, underrun_q;
  logic [23:0]        hold_q, last_sample_q, tx_word_q;
  logic               hold_full_q;
  logic               div_wrap, fall, boundary, accept;
  logic [4:0]         bit_idx;

  // Signed conversion: flipping the MSB maps offset-binary midscale onto zero.
  function automatic logic [23:0] conv(input logic [23:0] s);
    if (OFFSET_BINARY) return {~s[23], s[22:0]};
    else               return s;
  endfunction

  always_comb begin
    div_wrap  = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    fall      = div_wrap & bclk_q;
    bit_cnt_d = bit_cnt_q + 6'd1;
    boundary  = fall & (bit_cnt_q == 6'd63);
    accept    = sample_valid & ~hold_full_q;
    // Left slots 1..24 and right slots 33..56 share the same low 5 bits,
    // so one index serves both halves of the frame.
    bit_idx   = 5'd24 - bit_cnt_d[4:0];
    sdata_d   = 1'b0;
    if (bit_cnt_d[4:0] >= 5'd1 && bit_cnt_d[4:0] <= 5'd24)
      sdata_d = tx_word_q[bit_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      bit_cnt_q     <= 6'd63;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      last_sample_q <= MIDSCALE;
      tx_word_q     <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      if (div_wrap) bclk_q <= ~bclk_q;
      frame_start_q <= boundary;
      underrun_q    <= boundary & ~hold_full_q & (state_q != IDLE);

      if (fall) begin
        bit_cnt_q <= bit_cnt_d;
        lrclk_q   <= bit_cnt_d[5];
        sdata_q   <= sdata_d;
      end

      // accept only fires with the holding register empty, and the boundary
      // only clears it when full, so the two never fight over hold_full_q.
      if (accept) begin
        hold_q      <= sample_in;
        hold_full_q <= 1'b1;
      end

      if (boundary) begin
        if (hold_full_q) begin
          last_sample_q <= hold_q;
          hold_full_q   <= 1'b0;
          tx_word_q     <= mute ? 24'h0 : conv(hold_q);
          state_q       <= LEFT;
        end else begin
          tx_word_q <= (mute || state_q == IDLE) ? 24'h0 : conv(last_sample_q);
          if (state_q == RIGHT) state_q <= LEFT;
        end
      end else if (fall && bit_cnt_d == 6'd32 && state_q == LEFT) begin
        state_q <= RIGHT;
      end
    end
  end

  assign sample_ready = ~hold_full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
module tb_i2s_sample_transmitter;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready, bclk, lrclk, sdata, frame_start, underrun;

  int n_checks = 0;
  int n_pass   = 0;

  i2s_sample_transmitter #(.BCLK_DIV(D), .OFFSET_BINARY(1'b1)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .mute(mute), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [23:0] conv(input logic [23:0] s);
    return {~s[23], s[22:0]};
  endfunction

  // Expected 64-slot frame: index = slot number; word MSB-first in slots 1..24 and 33..56.
  function automatic logic [63:0] frame_of(input logic [23:0] w);
    logic [63:0] f;
    f = '0;
    for (int s = 1; s <= 24; s++) begin
      f[s]      = w[24 - s];
      f[s + 32] = w[24 - s];
    end
    return f;
  endfunction

  // ---------------- reference model (time-driven, from the frame rules) ----------------
  int          t = 0;
  bit          m_valid = 0, m_in_reset = 0;
  bit          m_hold_full = 0, m_started = 0, m_fall = 0, m_fs = 0, m_ur = 0, m_lr = 0, m_bclk = 0;
  int          m_slot = -1;
  logic [23:0] m_hold = '0, m_last = 24'h800000;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      t = 0; m_valid = 1; m_in_reset = 1;
      m_hold_full = 0; m_started = 0; m_last = 24'h800000;
      m_fall = 0; m_fs = 0; m_ur = 0; m_lr = 0; m_bclk = 0; m_slot = -1;
      exp_q.delete();
    end else if (m_valid) begin
      m_in_reset = 0;
      acc = sample_valid && !m_hold_full;
      t++;
      m_bclk = ((t / D) % 2) == 1;
      m_fall = (t % (2 * D)) == 0;
      m_fs = 0; m_ur = 0;
      if (m_fall) begin
        m_slot = ((t / (2 * D)) - 1) % 64;
        m_lr = (m_slot >= 32);
        if (m_slot == 0) begin
          m_fs = 1;
          if (m_hold_full) begin
            exp_q.push_back(mute ? 24'h0 : conv(m_hold));
            m_last = m_hold; m_started = 1; m_hold_full = 0;
          end else begin
            exp_q.push_back((mute || !m_started) ? 24'h0 : conv(m_last));
            m_ur = m_started;
          end
        end
      end
      if (acc) begin
        m_hold = sample_in; m_hold_full = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [63:0] got;
  bit          collecting = 0;

  always @(negedge clk) begin
    if (m_in_reset) begin
      collecting = 0;
      chk("rst_bclk", {63'd0, bclk}, 64'd0);
      chk("rst_lrclk", {63'd0, lrclk}, 64'd0);
      chk("rst_sdata", {63'd0, sdata}, 64'd0);
      chk("rst_frame_start", {63'd0, frame_start}, 64'd0);
      chk("rst_underrun", {63'd0, underrun}, 64'd0);
      chk("rst_ready", {63'd0, sample_ready}, 64'd1);
    end else if (m_valid) begin
      chk("bclk", {63'd0, bclk}, {63'd0, m_bclk});
      chk("lrclk", {63'd0, lrclk}, {63'd0, m_lr});
      chk("frame_start", {63'd0, frame_start}, {63'd0, m_fs});
      chk("underrun", {63'd0, underrun}, {63'd0, m_ur});
      chk("ready", {63'd0, sample_ready}, {63'd0, !m_hold_full});
      if (m_fall) begin
        if (m_slot == 0) begin
          collecting = 1; got = '0;
        end
        if (collecting) got[m_slot] = sdata;
        if (collecting && m_slot == 63) begin
          collecting = 0;
          if (exp_q.size() == 0) fail_now("frame_queue_empty");
          else chk("frame", got, frame_of(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (frame_start) return;
    end
    fail_now("wait_frame_start");
  endtask

  task automatic send(input logic [23:0] s);
    bit acc;
    sample_in = s; sample_valid = 1;
    for (int i = 0; i < 1000; i++) begin
      acc = sample_ready;
      @(posedge clk); #1;
      if (acc) begin
        sample_valid = 0;
        return;
      end
    end
    sample_valid = 0;
    fail_now("send_accept");
  endtask

  initial begin
    bit acc;
    reset = 1; cyc(3); reset = 0;
    cyc(600);                              // idle: zero frames, no underrun

    send(24'hC00001);                      // expect 0x400001 in both slots
    wait_fs(); wait_fs(); wait_fs();       // then a repeat with underrun

    sample_in = $urandom; sample_valid = 1; // valid held high: one accept per frame
    for (int i = 0; i < 4 * 256; i++) begin
      acc = sample_ready;
      @(posedge clk); #1;
      if (acc) sample_in = $urandom;
    end
    sample_valid = 0;

    wait_fs();
    send(24'hFFFFFF);
    mute = 1; wait_fs(); mute = 0;         // muted frame, hold consumed
    wait_fs(); wait_fs();                  // unmuted repeat: 0x7FFFFF

    wait_fs(); send(24'h123456); cyc(40 - 2);
    reset = 1; cyc(1); reset = 0;          // mid-frame reset discards held sample
    cyc(700);

    for (int i = 0; i < 8 * 256; i++) begin
      acc = sample_valid && sample_ready;
      @(posedge clk); #1;
      if (acc || !sample_valid) begin
        sample_in = $urandom;
        sample_valid = ($urandom_range(0, 3) == 0);
      end
      if (frame_start) mute = ($urandom_range(0, 4) == 0);
    end
    sample_valid = 0; mute = 0;
    cyc(600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_sample_transmitter.md
I2S_SAMPLE_TRANSMITTER -- requirements
Module: i2s_sample_transmitter

Interface
REQ-001 Parameter: BCLK_DIV, default 8, clk cycles per bclk half-period (minimum 2).
REQ-002 Parameter: OFFSET_BINARY, default 1; 1 = input is offset-binary (midscale 0x800000), 0 = input is two's complement.
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: sample_in  in  24  mono sample from the wave generator/mixer.
REQ-006 Port: sample_valid  in  1  sample_in is valid.
REQ-007 Port: sample_ready  out  1  holding register empty; the block accepts a sample when valid and ready are both high.
REQ-008 Port: mute  in  1  transmit zero audio, sampled at each frame boundary.
REQ-009 Port: bclk  out  1  I2S bit clock.
REQ-010 Port: lrclk  out  1  I2S word select; 0 = left, 1 = right.
REQ-011 Port: sdata  out  1  I2S serial data.
REQ-012 Port: frame_start  out  1  one-cycle pulse at each frame boundary.
REQ-013 Port: underrun  out  1  one-cycle pulse when a frame starts with no new sample.

Function
REQ-014 Divider: div_cnt counts 0..BCLK_DIV-1; bclk toggles on each wrap; bclk free-runs from the first cycle after reset.
REQ-015 Falling edge: the clk cycle in which bclk goes 1->0. bit_cnt (6 bits) increments on each falling edge and wraps 63->0.
REQ-016 Frame boundary: the falling edge on which bit_cnt wraps 63->0. frame_start is high for exactly that clk cycle.
REQ-017 lrclk and sdata update only on falling edges; lrclk = bit_cnt[5] after the update.
REQ-018 Bit placement (I2S, 1-bit delay): bit_cnt 1..24 carries tx_word[23:0] MSB-first (left); 33..56 carries the same word (right); all other slots carry sdata=0.
REQ-019 Conversion: if OFFSET_BINARY=1, tx_word = sample with bit 23 inverted; otherwise tx_word = sample unchanged.
REQ-020 Handshake: sample_ready = ~hold_full; on valid&ready, sample_in is written to hold and hold_full is set; the block ignores sample_valid while hold_full=1.
REQ-021 At each frame boundary with hold_full=1: hold -> last_sample, hold_full cleared, tx_word loaded from last_sample.
REQ-022 At each frame boundary with hold_full=0: tx_word is reloaded from the unchanged last_sample (repeat); underrun pulses for 1 cycle if state is not IDLE.
REQ-023 Simultaneous accept and frame boundary with hold_full=0: the sample goes to hold and is used at the next boundary; the current boundary counts as an underrun per REQ-022.
REQ-024 Mute: if mute=1 at a frame boundary, tx_word = 0 for that frame; hold is still consumed per REQ-021.
REQ-025 FSM states: IDLE, LEFT, RIGHT.
REQ-026 FSM transitions: IDLE->LEFT at the first boundary with hold_full=1; LEFT->RIGHT on the falling edge where bit_cnt becomes 32; RIGHT->LEFT at each frame boundary.
REQ-027 In IDLE, the block transmits zero words (tx_word=0) and suppresses underrun.
REQ-028 Latency: a sample accepted before boundary N has its MSB on sdata at the falling edge after boundary N.
REQ-029 Frame length is exactly 128*BCLK_DIV clk cycles; lrclk duty is exactly 50%.

Reset
REQ-030 On reset, all of the following SHALL hold for the cycle after reset is sampled high:
- bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, sample_ready=1.
- div_cnt=0, bit_cnt=63, state=IDLE, hold_full=0.
- last_sample=0x800000 if OFFSET_BINARY=1, else 0; tx_word=0.
REQ-031 Reset asserted mid-frame aborts the frame immediately; a held sample is discarded; the first falling edge after release is a frame boundary.

Verification (BCLK_DIV=2)
REQ-032 Scenario: reset, then idle for 600 cycles -> bclk period is 4 clk; frame_start pulses every 256 clk; sdata stays 0; underrun stays 0.
REQ-033 Scenario: sample_in 0xC00001 accepted before the first boundary -> left slot bits 1..24 = 0x400001, right slot bits 33..56 = 0x400001, all other slots 0.
REQ-034 Scenario: one sample, then no further samples -> the next frame repeats the word and underrun pulses once at that boundary.
REQ-035 Scenario: sample_valid held high continuously -> ready deasserts after the accept and reasserts the cycle after each boundary; exactly one accept per frame.
REQ-036 Scenario: mute=1 at a boundary with hold 0xFFFFFF -> that frame is all zeros; the next unmuted frame with no new sample sends 0x7FFFFF.
REQ-037 Scenario: reset pulsed at bit_cnt=10 -> outputs return to REQ-030 values the next cycle; hold_full=0.
